// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: constants, the decode
// register layout and the next-PC selection helper.
package fetch_unit_pkg;

   localparam int          CLOCK_PERIOD       = 10;
   localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_SEL_SEQ    = 2'd0,
      PC_SEL_HOLD   = 2'd1,
      PC_SEL_BRANCH = 2'd2
   } pc_sel_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus_4;
      logic        valid;
   } decode_reg_t;

   localparam decode_reg_t DECODE_BUBBLE = '{
      instr:     NOP_INSTR,
      pc:        32'h0000_0000,
      pc_plus_4: 32'h0000_0000,
      valid:     1'b0
   };

   // A taken branch outranks a stall so a redirect is never lost.
   function automatic pc_sel_e pc_select(input logic branch_taken, input logic stall);
      if (branch_taken)
         return PC_SEL_BRANCH;
      else if (stall)
         return PC_SEL_HOLD;
      else
         return PC_SEL_SEQ;
   endfunction

endpackage

// File: rtl/fetch_unit_program_counter.sv
// Fetch-address register and next-PC mux. Only the word index is stored, so
// the two byte-offset bits of PC_Out are zero by construction.
module program_counter
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall_F,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   output logic [31:0] PC_Out
);

   logic [29:0] pc_word;
   logic [29:0] pc_word_next;
   pc_sel_e     sel;
   logic        unused_target_lsbs;

   assign unused_target_lsbs = ^Branch_Target[1:0];
   assign sel                = pc_select(Branch_Taken, Stall_F);

   // NOTE: default assignment first so every path drives pc_word_next; no latch.
   always_comb begin
      pc_word_next = pc_word;
      unique case (sel)
         PC_SEL_BRANCH: pc_word_next = Branch_Target[31:2];
         PC_SEL_HOLD:   pc_word_next = pc_word;
         PC_SEL_SEQ:    pc_word_next = pc_word + 30'd1;  // wraps at 2^30 words
         default:       pc_word_next = pc_word;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         pc_word <= RESET_ADDR[31:2];
      else
         pc_word <= pc_word_next;
   end

   assign PC_Out = {pc_word, 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter plus the fetch/decode pipeline
// register. Instruction memory sits outside and answers PC_Out on Instr.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall_F,
   input  logic        Flush_D,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   input  logic [31:0] Instr,
   output logic [31:0] PC_Out,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC_Plus_4_D,
   output logic        Valid_D
);

   decode_reg_t dec_q;
   decode_reg_t dec_next;

   program_counter #(
      .RESET_ADDR (RESET_ADDR)
   ) u_pc (
      .CLK           (CLK),
      .RST           (RST),
      .Stall_F       (Stall_F),
      .Branch_Taken  (Branch_Taken),
      .Branch_Target (Branch_Target),
      .PC_Out        (PC_Out)
   );

   // The word fetched in a redirect cycle is on the wrong path, so a branch
   // squashes it exactly like an explicit flush.
   always_comb begin
      dec_next = dec_q;
      if (Branch_Taken || Flush_D)
         dec_next = DECODE_BUBBLE;
      else if (!Stall_F)
         dec_next = '{
            instr:     Instr,
            pc:        PC_Out,
            pc_plus_4: PC_Out + 32'd4,
            valid:     1'b1
         };
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         dec_q <= DECODE_BUBBLE;
      else
         dec_q <= dec_next;
   end

   assign Instr_D     = dec_q.instr;
   assign PC_D        = dec_q.pc;
   assign PC_Plus_4_D = dec_q.pc_plus_4;
   assign Valid_D     = dec_q.valid;

endmodule
